// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage with data memory, sub-word loads and stores, and a write-back mux.
// Stores commit on the rising clock edge. Loads read combinationally and see the contents from before that edge.
module mem_stage #(
    parameter int DM_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] InstrM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] ForwardM2,
    input  logic [4:0]  A3M,
    input  logic [31:0] WDM,
    input  logic [31:0] PCM,
    output logic [4:0]  A3MW,
    output logic [31:0] WDMW
);
    localparam int AW = $clog2(DM_WORDS);

    logic [31:0]   mem_q [DM_WORDS];
    logic [31:0]   mem_d, rd_word, lane_mask, lane_data, load_val;
    logic [AW-1:0] widx;
    logic [5:0]    op;
    logic [4:0]    sh_amt;
    logic [15:0]   half;
    logic [7:0]    byte_v;
    logic          is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw;
    logic          mem_write, gen_m, load_signed;
    logic          unused_ok;

    assign unused_ok = ^{InstrM[25:21], InstrM[15:0], ALUOutM};

    always_comb begin
        op          = InstrM[31:26];
        is_lb       = op == 6'h20;
        is_lh       = op == 6'h21;
        is_lw       = op == 6'h23;
        is_lbu      = op == 6'h24;
        is_lhu      = op == 6'h25;
        is_sb       = op == 6'h28;
        is_sh       = op == 6'h29;
        is_sw       = op == 6'h2B;
        mem_write   = is_sb | is_sh | is_sw;
        gen_m       = is_lb | is_lh | is_lw | is_lbu | is_lhu;
        load_signed = is_lb | is_lh;
        widx        = ALUOutM[AW+1:2];
        rd_word     = mem_q[widx];
        sh_amt      = {ALUOutM[1:0], 3'b000};
        half        = ALUOutM[1] ? rd_word[31:16] : rd_word[15:0];
        byte_v      = 8'(rd_word >> sh_amt);
        load_val    = is_lw ? rd_word :
                      (is_lh | is_lhu) ? {{16{load_signed & half[15]}}, half} :
                      {{24{load_signed & byte_v[7]}}, byte_v};
        // Read-modify-write merge: the lane mask selects which bytes the store replaces.
        lane_mask   = is_sw ? 32'hFFFF_FFFF :
                      is_sh ? (ALUOutM[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) :
                      32'h0000_00FF << sh_amt;
        lane_data   = is_sw ? ForwardM2 : is_sh ? {2{ForwardM2[15:0]}} : {4{ForwardM2[7:0]}};
        mem_d       = (rd_word & ~lane_mask) | (lane_data & lane_mask);
        A3MW        = gen_m ? InstrM[20:16] : A3M;
        WDMW        = gen_m ? load_val : WDM;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
        end else if (mem_write) begin
            mem_q[widx] <= mem_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge Clk) begin
        if (!Reset && mem_write) $display("@%h: *%h <= %h", PCM, {ALUOutM[31:2], 2'b00}, mem_d);
    end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: byte-array reference model of the memory stage, checked on every falling edge, plus directed literal checks.
module tb_mem_stage;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] InstrM, ALUOutM, ForwardM2, WDM, PCM;
    logic [4:0]  A3M;
    logic [4:0]  A3MW;
    logic [31:0] WDMW;
    int          tests = 0;
    int          fails = 0;
    bit          chk_en = 1'b0;
    logic [7:0]  bm [4096];

    always #5 Clk = ~Clk;

    mem_stage dut (
        .Clk(Clk), .Reset(Reset), .InstrM(InstrM), .ALUOutM(ALUOutM), .ForwardM2(ForwardM2),
        .A3M(A3M), .WDM(WDM), .PCM(PCM), .A3MW(A3MW), .WDMW(WDMW)
    );

    function automatic bit is_load(input logic [5:0] op);
        return op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25;
    endfunction

    function automatic bit is_store(input logic [5:0] op);
        return op == 6'h28 || op == 6'h29 || op == 6'h2B;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a);
        int b = int'(a % 4096);
        int w0 = b - b % 4;
        int h0 = b - b % 2;
        logic [15:0] h = {bm[h0 + 1], bm[h0]};
        logic [7:0] y = bm[b];
        case (op)
            6'h23:   return {bm[w0 + 3], bm[w0 + 2], bm[w0 + 1], bm[w0]};
            6'h21:   return {{16{h[15]}}, h};
            6'h25:   return {16'h0000, h};
            6'h20:   return {{24{y[7]}}, y};
            default: return {24'h000000, y};
        endcase
    endfunction

    task automatic model_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        int b = int'(a % 4096);
        int w0 = b - b % 4;
        int h0 = b - b % 2;
        if (op == 6'h2B) begin
            for (int k = 0; k < 4; k++) bm[w0 + k] = d[8*k +: 8];
        end else if (op == 6'h29) begin
            bm[h0] = d[7:0];
            bm[h0 + 1] = d[15:8];
        end else begin
            bm[b] = d[7:0];
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4096; k++) bm[k] = 8'h00;
    endtask

    always @(negedge Clk) begin : cmp
        logic [4:0]  ea;
        logic [31:0] ew;
        if (chk_en) begin
            ea = is_load(InstrM[31:26]) ? InstrM[20:16] : A3M;
            ew = is_load(InstrM[31:26]) ? model_load(InstrM[31:26], ALUOutM) : WDM;
            tests++;
            if (A3MW !== ea || WDMW !== ew) begin
                fails++;
                $display("FAIL cmp t=%0t op=%h addr=%h got A3MW=%h WDMW=%h expected A3MW=%h WDMW=%h",
                         $time, InstrM[31:26], ALUOutM, A3MW, WDMW, ea, ew);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rt, input logic [4:0] a3, input logic [31:0] wd);
        InstrM    = {op, 5'($urandom), rt, 16'($urandom)};
        ALUOutM   = a;
        ForwardM2 = d;
        A3M       = a3;
        WDM       = wd;
        PCM       = 32'h0040_0000 + 32'($urandom_range(0, 255)) * 4;
        #1;
    endtask

    task automatic fin();
        @(negedge Clk);
        @(posedge Clk);
        #1;
        if (!Reset && is_store(InstrM[31:26])) model_store(InstrM[31:26], ALUOutM, ForwardM2);
    endtask

    initial begin
        Reset = 1'b1;
        model_clear();
        set(6'h00, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0);
        #12;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        chk_en = 1'b1;

        set(6'h23, 32'h0, 32'h0, 5'd7, 5'd3, 32'h1111_1111);
        lit("reset_lw_data", WDMW, 32'h0000_0000);
        lit("reset_lw_a3", 32'(A3MW), 32'd7);
        fin();
        set(6'h2B, 32'h10, 32'h1234_5678, 5'd9, 5'd2, 32'h2222_2222);
        lit("sw_passthru_a3", 32'(A3MW), 32'd2);
        fin();
        set(6'h23, 32'h10, 32'h0, 5'd4, 5'd0, 32'h0);
        lit("lw_after_sw", WDMW, 32'h1234_5678);
        fin();
        set(6'h28, 32'h11, 32'h0000_00AB, 5'd0, 5'd0, 32'h0);
        fin();
        set(6'h23, 32'h10, 32'h0, 5'd0, 5'd0, 32'h0);
        lit("word_after_sb", WDMW, 32'h1234_AB78);
        set(6'h20, 32'h11, 32'h0, 5'd0, 5'd0, 32'h0);
        lit("lb_0x11", WDMW, 32'hFFFF_FFAB);
        set(6'h24, 32'h11, 32'h0, 5'd0, 5'd0, 32'h0);
        lit("lbu_0x11", WDMW, 32'h0000_00AB);
        fin();
        set(6'h29, 32'h12, 32'h0000_8001, 5'd0, 5'd0, 32'h0);
        fin();
        set(6'h23, 32'h10, 32'h0, 5'd0, 5'd0, 32'h0);
        lit("word_after_sh", WDMW, 32'h8001_AB78);
        set(6'h21, 32'h12, 32'h0, 5'd0, 5'd0, 32'h0);
        lit("lh_0x12", WDMW, 32'hFFFF_8001);
        set(6'h25, 32'h12, 32'h0, 5'd0, 5'd0, 32'h0);
        lit("lhu_0x12", WDMW, 32'h0000_8001);
        set(6'h21, 32'h13, 32'h0, 5'd0, 5'd0, 32'h0);
        lit("lh_bit0_ignored", WDMW, 32'hFFFF_8001);
        fin();
        set(6'h00, 32'h10, 32'h5555_5555, 5'd0, 5'd5, 32'hDEAD_BEEF);
        lit("rtype_a3", 32'(A3MW), 32'd5);
        lit("rtype_wd", WDMW, 32'hDEAD_BEEF);
        fin();
        set(6'h23, 32'h10, 32'h0, 5'd0, 5'd0, 32'h0);
        lit("rtype_mem_unchanged", WDMW, 32'h8001_AB78);
        fin();
        set(6'h2B, 32'h1010, 32'hCAFE_F00D, 5'd0, 5'd0, 32'h0);
        fin();
        set(6'h23, 32'h10, 32'h0, 5'd0, 5'd0, 32'h0);
        lit("wrap_write_idx4", WDMW, 32'hCAFE_F00D);
        #2;
        Reset = 1'b1;
        model_clear();
        #1;
        lit("async_reset_read", WDMW, 32'h0000_0000);
        fin();
        set(6'h2B, 32'h10, 32'h1111_1111, 5'd0, 5'd0, 32'h0);
        fin();
        Reset = 1'b0;
        set(6'h23, 32'h10, 32'h0, 5'd0, 5'd0, 32'h0);
        lit("no_store_in_reset", WDMW, 32'h0000_0000);
        fin();

        for (int n = 0; n < 3000; n++) begin
            logic [5:0] ops [10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h0F};
            logic [5:0] op;
            op = ($urandom_range(0, 19) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 299) == 0) begin
                Reset = 1'b1;
                model_clear();
                #1;
                Reset = 1'b0;
            end
            set(op, ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom,
                5'($urandom), 5'($urandom), $urandom);
            fin();
        end
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DM_WORDS, default 1024, SHALL set the number of 32-bit data-memory words (word index = Addr[11:2] at default).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset: Clk and Reset.
REQ-003 Clk  input  1  rising-edge clock for memory writes.
REQ-004 Reset  input  1  asynchronous, active-high; clears data memory.
REQ-005 InstrM  input  32  instruction in M stage; opcode is InstrM[31:26], rt is InstrM[20:16].
REQ-006 ALUOutM  input  32  byte address of the memory access.
REQ-007 ForwardM2  input  32  store data (rt value, already forwarded).
REQ-008 A3M  input  5  destination register carried from earlier stages.
REQ-009 WDM  input  32  write-back data carried from earlier stages.
REQ-010 PCM  input  32  PC of the M-stage instruction, used for the store log only.
REQ-011 A3MW  output  5  destination register leaving M stage.
REQ-012 WDMW  output  32  write-back data leaving M stage.

Function
REQ-013 Decode SHALL be combinational from InstrM[31:26]: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B.
REQ-014 Decode SHALL produce MemWrite (sb/sh/sw), width (word/half/byte), LoadSigned (lb/lh) and GenM (any of the five loads); every other opcode SHALL give MemWrite=0 and GenM=0.
REQ-015 When GenM=0, A3MW SHALL equal A3M and WDMW SHALL equal WDM, combinationally.
REQ-016 When GenM=1, A3MW SHALL equal InstrM[20:16] and WDMW SHALL equal the loaded value in the same cycle (combinational read, zero latency).
REQ-017 Word address SHALL be ALUOutM[11:2] (low log2(DM_WORDS) bits above bit 1); higher address bits SHALL be ignored, so accesses wrap.
REQ-018 lw SHALL return the full word, ignoring ALUOutM[1:0].
REQ-019 lh/lhu SHALL select halfword ALUOutM[1] (1 = bits 31:16, 0 = bits 15:0), ignoring bit 0; lh sign-extends, lhu zero-extends.
REQ-020 lb/lbu SHALL select byte lane ALUOutM[1:0] (lane 0 = bits 7:0); lb sign-extends, lbu zero-extends.
REQ-021 A store SHALL update memory on the rising Clk edge when MemWrite=1 and Reset=0.
REQ-022 sw SHALL write all 32 bits of ForwardM2.
REQ-023 sh SHALL write ForwardM2[15:0] into the selected halfword only.
REQ-024 sb SHALL write ForwardM2[7:0] into the selected byte lane only.
REQ-025 Unselected bytes SHALL keep their values during sh and sb.
REQ-026 A load in the same cycle as a write edge SHALL see pre-edge contents; only one instruction occupies M at a time, so read/write conflict is only a clock-edge ordering.
REQ-027 Each store SHALL emit one simulation log line: "@<PCM hex>: *<word-aligned address hex> <= <full resulting 32-bit word hex>". The log SHALL be simulation-only and SHALL NOT affect synthesis.
REQ-028 Misaligned addresses SHALL NOT raise any exception or flag.

Reset
REQ-029 Reset=1 SHALL clear every memory word to 0x00000000 immediately, without waiting for Clk.
REQ-030 While Reset=1, no store SHALL take effect.
REQ-031 A3MW and WDMW have no registers and SHALL follow their inputs and memory contents, so loads read 0 after reset.
REQ-032 Reset asserted mid-operation SHALL discard all previously stored data.

Verification
REQ-033 Reset, then lw addr 0x0 -> WDMW=0x00000000; A3MW = InstrM[20:16].
REQ-034 sw 0x12345678 to 0x10, then lw 0x10 -> WDMW=0x12345678; log "@<PC>: *00000010 <= 12345678".
REQ-035 sw 0x12345678 to 0x10, then sb 0xAB to 0x11 -> word 0x1234AB78; lb 0x11 -> 0xFFFFFFAB; lbu 0x11 -> 0x000000AB.
REQ-036 From word 0x1234AB78, sh 0x8001 to 0x12 -> word 0x8001AB78; lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001.
REQ-037 Non-memory opcode (e.g. 0x00 R-type) with A3M=5, WDM=0xDEADBEEF -> A3MW=5, WDMW=0xDEADBEEF; memory unchanged; no log line.
REQ-038 sw to 0x1010 -> word index 4 is written (wrap); asserting Reset between clock edges -> immediate reads return 0.
